// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster timing controller with pixel fetch and two-stage output pipeline
//
// Ports:
//   CLK          pixel clock
//   RST_N        asynchronous active-low reset
//   ENABLE       run request; dropping it lets the current frame finish
//   PIX_RGB[2:0] pixel data from the source, valid the cycle after PIX_REQ
//   PIX_REQ      pixel fetch strobe (stage 1)
//   PIX_X[9:0]   column of the requested pixel, 0 when PIX_REQ=0
//   PIX_Y[9:0]   row of the requested pixel, 0 when PIX_REQ=0
//   FRAME_START  one-cycle pulse alongside the request for pixel (0,0)
//   HSYNC/VSYNC  sync outputs, aligned with DE, active level HS_POL/VS_POL
//   DE           display enable (stage 2)
//   RGB[2:0]     video out, forced to 0 whenever DE=0
//   BUSY         high while a frame is being scanned (RUN or DRAIN)

module vga_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       ENABLE,
    input  logic [2:0] PIX_RGB,
    output logic       PIX_REQ,
    output logic [9:0] PIX_X,
    output logic [9:0] PIX_Y,
    output logic       FRAME_START,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       DE,
    output logic [2:0] RGB,
    output logic       BUSY
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region bounds are 11 bits wide so an end bound of exactly 1024 still compares correctly.
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t     state;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    logic        scanning;
    logic        at_end;
    logic        in_active;
    logic        in_hsync;
    logic        in_vsync;
    logic [10:0] h_ext;
    logic [10:0] v_ext;

    // Stage-1 sync flags and the intermediate stage where PIX_RGB becomes valid.
    // Sync flags are kept active-high internally; polarity is applied at the output.
    logic s1_hs;
    logic s1_vs;
    logic s1p_req;
    logic s1p_hs;
    logic s1p_vs;

    assign h_ext     = {1'b0, h_cnt};
    assign v_ext     = {1'b0, v_cnt};
    assign scanning  = (state != S_IDLE);
    assign at_end    = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign in_active = (h_ext < H_ACT) && (v_ext < V_ACT);
    assign in_hsync  = (h_ext >= HS_BEGIN) && (h_ext < HS_END);
    assign in_vsync  = (v_ext >= VS_BEGIN) && (v_ext < VS_END);
    assign BUSY      = scanning;

    // State and raster counters. Counters hold at (0,0) in IDLE, so the first
    // RUN cycle scans (0,0). RUN and DRAIN both advance the counters; DRAIN only
    // differs in that it stops at the frame's last position.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (ENABLE) begin
                        state <= S_RUN;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (h_cnt == H_LAST) begin
                        h_cnt <= '0;
                        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
                    end else begin
                        h_cnt <= h_cnt + 10'd1;
                    end
                    // A stop request landing on the last position ends the frame
                    // right there instead of draining a whole extra frame.
                    if (ENABLE) begin
                        state <= S_RUN;
                    end else if (at_end) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_DRAIN;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    h_cnt <= '0;
                    v_cnt <= '0;
                end
            endcase
        end
    end

    // Stage 1: fetch request registered from the counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PIX_REQ     <= 1'b0;
            PIX_X       <= '0;
            PIX_Y       <= '0;
            FRAME_START <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
        end else begin
            PIX_REQ     <= scanning && in_active;
            PIX_X       <= (scanning && in_active) ? h_cnt : 10'd0;
            PIX_Y       <= (scanning && in_active) ? v_cnt : 10'd0;
            FRAME_START <= scanning && (h_cnt == 10'd0) && (v_cnt == 10'd0);
            s1_hs       <= scanning && in_hsync;
            s1_vs       <= scanning && in_vsync;
        end
    end

    // Intermediate stage (source returns PIX_RGB now) and stage 2 outputs.
    // These keep shifting in IDLE so the tail of the last frame flushes out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1p_req <= 1'b0;
            s1p_hs  <= 1'b0;
            s1p_vs  <= 1'b0;
            DE      <= 1'b0;
            RGB     <= '0;
            HSYNC   <= ~HS_POL;
            VSYNC   <= ~VS_POL;
        end else begin
            s1p_req <= PIX_REQ;
            s1p_hs  <= s1_hs;
            s1p_vs  <= s1_vs;
            DE      <= s1p_req;
            RGB     <= s1p_req ? PIX_RGB : 3'd0;
            HSYNC   <= s1p_hs ? HS_POL : ~HS_POL;
            VSYNC   <= s1p_vs ? VS_POL : ~VS_POL;
        end
    end

endmodule
